// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, error codes, FSM states, fixed latencies and the result function.
// Purely declarative; no clocked logic lives here.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_ISSUE,
    REQ_WAIT,
    REQ_RESP
  } req_state_t;

  typedef enum logic [1:0] {
    ALU_IDLE,
    ALU_CALC,
    ALU_DIVIDE,
    ALU_FINISH
  } alu_state_t;

  // Cycles from the start pulse to the done pulse.
  localparam int CALC_LAT = 2;
  localparam int DIV_LAT  = 33;

  // Division carries one fixed decimal place: floor(a*10/b).
  function automatic logic [31:0] alu_compute(input logic [15:0] a, input logic [15:0] b,
                                              input op_t op);
    logic [31:0] wa;
    logic [31:0] wb;
    wa = {16'b0, a};
    wb = {16'b0, b};
    case (op)
      OP_ADD:  return wa + wb;
      OP_SUB:  return wa - wb;
      OP_MUL:  return wa * wb;
      default: return (wb == 32'd0) ? 32'd0 : (wa * 32'd10) / wb;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Multi-cycle ALU: start pulse, done two cycles later (33 for divide), result held until the next op.
// Operands are read continuously while busy, so the client must hold them stable.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  input  logic [1:0]  op_code,
  output logic [31:0] result,
  output logic        is_division,
  output logic        done
);

  op_t        op;
  alu_state_t state, state_nxt;
  logic [5:0] cnt;
  logic       busy_last;

  assign op        = op_t'(op_code);
  assign busy_last = (state == ALU_CALC || state == ALU_DIVIDE) && (cnt == 6'd1);
  assign done      = (state == ALU_FINISH);

  always_comb begin
    state_nxt = state;
    case (state)
      ALU_IDLE:              if (start) state_nxt = (op == OP_DIV) ? ALU_DIVIDE : ALU_CALC;
      ALU_CALC, ALU_DIVIDE:  if (busy_last) state_nxt = ALU_FINISH;
      ALU_FINISH:            state_nxt = ALU_IDLE;
      default:               state_nxt = ALU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ALU_IDLE;
      cnt         <= '0;
      result      <= '0;
      is_division <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ALU_IDLE && start) begin
        cnt <= (op == OP_DIV) ? 6'(DIV_LAT - 1) : 6'(CALC_LAT - 1);
      end else if (cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
      end
      if (busy_last) begin
        result      <= alu_compute(num1, num2, op);
        is_division <= (op == OP_DIV);
      end
    end
  end

endmodule

// File: rtl/watchdog_timer.sv
// WAIT-cycle watchdog: clear loads 1 (the first counted cycle), enable advances the count.
// expired is high while enabled at the terminal count TIMEOUT_CYCLES.
module watchdog_timer #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= W'(1);
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/alu_requester.sv
// ALU client: one command in flight, start pulse one cycle after accept, response held until rsp_ready.
// Divide-by-zero answered locally; a watchdog turns a hung ALU into a TIMEOUT response.
module alu_requester
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_num1,
  input  logic [15:0] cmd_num2,
  input  logic [1:0]  cmd_op,
  output logic        alu_start,
  output logic [15:0] alu_num1,
  output logic [15:0] alu_num2,
  output logic [1:0]  alu_op_code,
  input  logic [31:0] alu_result,
  input  logic        alu_is_division,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_is_division,
  output logic [1:0]  rsp_err
);

  req_state_t  state, state_nxt;
  logic        ready_en;
  op_t         op_q;
  err_t        err_q;
  logic        accept;
  logic        div0;
  logic        timer_clear;
  logic        timer_en;
  logic        timer_expired;

  // ready_en keeps cmd_ready low while reset is held even though the state is IDLE.
  assign cmd_ready   = ready_en && (state == REQ_IDLE);
  assign accept      = cmd_ready && cmd_valid;
  assign div0        = (op_t'(cmd_op) == OP_DIV) && (cmd_num2 == 16'd0);
  assign alu_start   = (state == REQ_ISSUE);
  assign rsp_valid   = (state == REQ_RESP);
  assign alu_op_code = op_q;
  assign rsp_err     = err_q;

  always_comb begin
    state_nxt   = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state)
      REQ_IDLE:  if (accept) state_nxt = div0 ? REQ_RESP : REQ_ISSUE;
      REQ_ISSUE: begin
        timer_clear = 1'b1;
        state_nxt   = REQ_WAIT;
      end
      REQ_WAIT: begin
        timer_en = 1'b1;
        if (alu_done || timer_expired) state_nxt = REQ_RESP;
      end
      REQ_RESP:  if (rsp_ready) state_nxt = REQ_IDLE;
      default:   state_nxt = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= REQ_IDLE;
      ready_en        <= 1'b0;
      alu_num1        <= '0;
      alu_num2        <= '0;
      op_q            <= OP_ADD;
      rsp_result      <= '0;
      rsp_is_division <= 1'b0;
      err_q           <= ERR_OK;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (accept) begin
        alu_num1 <= cmd_num1;
        alu_num2 <= cmd_num2;
        op_q     <= op_t'(cmd_op);
        if (div0) begin
          rsp_result      <= '0;
          rsp_is_division <= 1'b1;
          err_q           <= ERR_DIV0;
        end
      end
      // done outranks a coincident timeout.
      if (state == REQ_WAIT) begin
        if (alu_done) begin
          rsp_result      <= alu_result;
          rsp_is_division <= alu_is_division;
          err_q           <= ERR_OK;
        end else if (timer_expired) begin
          rsp_result      <= '0;
          rsp_is_division <= (op_q == OP_DIV);
          err_q           <= ERR_TIMEOUT;
        end
      end
    end
  end

  watchdog_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

endmodule

// File: tb/tb_alu_requester.sv
// Bench for alu_requester driving a real alu; done can be masked to emulate a hung ALU.
module tb_alu_requester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_num1 = '0;
  logic [15:0] cmd_num2 = '0;
  logic [1:0]  cmd_op = '0;
  logic        alu_start;
  logic [15:0] alu_num1;
  logic [15:0] alu_num2;
  logic [1:0]  alu_op_code;
  logic [31:0] alu_result;
  logic        alu_is_division;
  logic        real_done;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_is_division;
  logic [1:0]  rsp_err;
  logic        stub_mode = 1'b0;
  logic        stub_done = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign alu_done = stub_mode ? stub_done : real_done;

  alu_requester #(.TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_op(cmd_op),
    .alu_start(alu_start), .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op_code(alu_op_code),
    .alu_result(alu_result), .alu_is_division(alu_is_division), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_is_division(rsp_is_division), .rsp_err(rsp_err)
  );

  alu u_alu (
    .clk(clk), .rst_n(rst_n), .start(alu_start),
    .num1(alu_num1), .num2(alu_num2), .op_code(alu_op_code),
    .result(alu_result), .is_division(alu_is_division), .done(real_done)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        div;
    logic [1:0]  err;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation's meaning, latencies counted from the accept cycle.
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [31:0] res, output logic div,
                                output logic [1:0] err, output int lat);
    longint x = longint'(a);
    longint y = longint'(b);
    div = (op == 2'd3);
    err = 2'd0;
    lat = 4;
    case (op)
      2'd0: res = 32'(x + y);
      2'd1: res = 32'((x - y + 64'h1_0000_0000) % 64'h1_0000_0000);
      2'd2: res = 32'(x * y);
      default: begin
        lat = 35;
        if (y == 0) begin
          res = 32'd0;
          err = 2'd1;
          lat = 1;
        end else begin
          res = 32'((x * 10) / y);
        end
      end
    endcase
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] eres, input logic ediv, input logic [1:0] eerr,
                         input int elat, input int hold, input string tag);
    int   n;
    int   lat;
    int   starts;
    logic stable;
    logic hold_ok;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_num1  = a;
    cmd_num2  = b;
    tick();
    cmd_valid = 1'b0;
    cmd_num1  = 16'($urandom);
    cmd_num2  = 16'($urandom);
    cmd_op    = 2'($urandom);
    lat    = 1;
    starts = 0;
    stable = 1'b1;
    while (!rsp_valid && lat < 100) begin
      if (alu_start) starts++;
      if (starts > 0 && (alu_num1 !== a || alu_num2 !== b || alu_op_code !== op)) stable = 1'b0;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " start pulses"}, 32'(starts), (eerr == 2'd1) ? 32'd0 : 32'd1);
    chk({tag, " operands stable"}, 32'(stable), 32'd1);
    chk({tag, " result"}, rsp_result, eres);
    chk({tag, " is_division"}, 32'(rsp_is_division), 32'(ediv));
    chk({tag, " err"}, 32'(rsp_err), 32'(eerr));
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!rsp_valid || cmd_ready || rsp_result !== eres || rsp_err !== eerr ||
            rsp_is_division !== ediv) hold_ok = 1'b0;
      end
      chk({tag, " held under backpressure"}, 32'(hold_ok), 32'd1);
      rsp_ready = 1'b1;
    end
    tick();
    chk({tag, " after handshake {rsp_valid,cmd_ready}"}, 32'({rsp_valid, cmd_ready}), 32'b01);
  endtask

  initial begin
    #400000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] mres;
    logic        mdiv;
    logic [1:0]  merr;
    int          mlat;
    logic [1:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        seen;

    tbl[0] = '{2'd0, 16'd1200,   16'd34,     32'd1234,        1'b0, 2'd0, 4};
    tbl[1] = '{2'd1, 16'd3,      16'd5,      32'hFFFF_FFFE,   1'b0, 2'd0, 4};
    tbl[2] = '{2'd2, 16'd300,    16'd400,    32'd120000,      1'b0, 2'd0, 4};
    tbl[3] = '{2'd3, 16'd7,      16'd2,      32'd35,          1'b1, 2'd0, 35};
    tbl[4] = '{2'd3, 16'd9,      16'd0,      32'd0,           1'b1, 2'd1, 1};
    tbl[5] = '{2'd0, 16'hFFFF,   16'hFFFF,   32'h0001_FFFE,   1'b0, 2'd0, 4};
    tbl[6] = '{2'd2, 16'hFFFF,   16'hFFFF,   32'hFFFE_0001,   1'b0, 2'd0, 4};
    tbl[7] = '{2'd3, 16'hFFFF,   16'd1,      32'd655350,      1'b1, 2'd0, 35};
    tbl[8] = '{2'd3, 16'd1,      16'd3,      32'd3,           1'b1, 2'd0, 35};
    tbl[9] = '{2'd1, 16'd0,      16'd0,      32'd0,           1'b0, 2'd0, 4};

    repeat (3) tick();
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset control outs", 32'({alu_start, rsp_valid, rsp_is_division, rsp_err, alu_op_code}), 32'd0);
    chk("reset operands", {alu_num1, alu_num2}, 32'd0);
    chk("reset rsp_result", rsp_result, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post-reset {alu_start,rsp_valid}", 32'({alu_start, rsp_valid}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].div, tbl[i].err,
              tbl[i].lat, 0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 25; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (rop == 2'd3 && $urandom_range(0, 3) == 0) rb = 16'd0;
      model(rop, ra, rb, mres, mdiv, merr, mlat);
      run_cmd(rop, ra, rb, mres, mdiv, merr, mlat, 0, $sformatf("rand%0d", i));
    end

    run_cmd(2'd0, 16'd10, 16'd20, 32'd30, 1'b0, 2'd0, 4, 10, "backpressure add");
    run_cmd(2'd3, 16'd7, 16'd0, 32'd0, 1'b1, 2'd1, 1, 10, "backpressure div0");

    stub_mode = 1'b1;
    run_cmd(2'd3, 16'd50, 16'd5, 32'd0, 1'b1, 2'd2, 42, 0, "timeout div");
    run_cmd(2'd0, 16'd1, 16'd1, 32'd0, 1'b0, 2'd2, 42, 0, "timeout add");
    stub_done = 1'b1;
    tick();
    stub_done = 1'b0;
    chk("late done ignored rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("late done ignored {rsp_valid,cmd_ready}", 32'({rsp_valid, cmd_ready}), 32'b01);
    stub_mode = 1'b0;
    run_cmd(2'd2, 16'd12, 16'd12, 32'd144, 1'b0, 2'd0, 4, 0, "after timeout mul");

    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_num1  = 16'd100;
    cmd_num2  = 16'd3;
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    chk("mid-div in flight", 32'({alu_op_code, cmd_ready}), 32'b110);
    rst_n = 1'b0;
    #1;
    chk("async reset control outs",
        32'({cmd_ready, alu_start, rsp_valid, rsp_is_division, rsp_err, alu_op_code}), 32'd0);
    chk("async reset operands", {alu_num1, alu_num2}, 32'd0);
    chk("async reset rsp_result", rsp_result, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rsp_valid || alu_start) seen = 1'b1;
    end
    chk("no response after reset", 32'(seen), 32'd0);
    run_cmd(2'd3, 16'd100, 16'd3, 32'd333, 1'b1, 2'd0, 35, 0, "after reset div");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
